// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch controller.
package fetch_pkg;

   typedef enum logic [2:0] {
      StIdle,
      StInit,
      StFetch,
      StIssue,
      StHalted
   } state_e;

   localparam int unsigned ADDR_W_DEF  = 16;
   localparam int unsigned INSTR_W_DEF = 16;
   localparam int unsigned CNT_W       = 16;
   localparam logic [CNT_W-1:0] CNT_MAX = 16'hFFFF;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear and asynchronous active-high reset.
module sat_counter
   import fetch_pkg::*;
#(
   parameter int unsigned       Width = CNT_W,
   parameter logic [Width-1:0]  Max   = CNT_MAX
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             clear_i,
   input  logic             en_i,
   output logic [Width-1:0] count_o
);

   logic [Width-1:0] count_d, count_q;

   always_comb begin
      count_d = count_q;
      if (clear_i) begin
         count_d = '0;
      end else if (en_i && (count_q != Max)) begin
         count_d = count_q + 1'b1;
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   assign count_o = count_q;

endmodule

// File: rtl/fetch_ctrl.sv
// Fetch/issue sequencer: drives PC-unit commands, fetches from instruction memory,
// presents each instruction to decode and counts active cycles.
module fetch_ctrl
   import fetch_pkg::*;
#(
   parameter int unsigned ADDR_W  = ADDR_W_DEF,
   parameter int unsigned INSTR_W = INSTR_W_DEF
) (
   input  logic               CLK,
   input  logic               Reset,
   input  logic               Start,
   input  logic               MemAck,
   input  logic [INSTR_W-1:0] MemData,
   input  logic               Stall,
   input  logic               BranchReq,
   input  logic [ADDR_W-1:0]  BranchTarget,
   input  logic               HaltReq,
   output logic               Init,
   output logic               Halt,
   output logic               Branch_abs,
   output logic [ADDR_W-1:0]  Target,
   output logic               MemReq,
   output logic               InstrValid,
   output logic [INSTR_W-1:0] Instr,
   output logic               Done,
   output logic [CNT_W-1:0]   CycleCount
);

   state_e             state_d, state_q;
   logic [INSTR_W-1:0] instr_d, instr_q;
   logic               start_go;
   logic               cnt_clear;
   logic               cnt_en;

   assign start_go = Start && ((state_q == StIdle) || (state_q == StHalted));

   always_comb begin
      state_d    = state_q;
      instr_d    = instr_q;
      Init       = 1'b0;
      Halt       = 1'b0;
      Branch_abs = 1'b0;
      Target     = '0;
      MemReq     = 1'b0;
      InstrValid = 1'b0;
      Done       = 1'b0;
      unique case (state_q)
         StIdle: begin
            Halt = 1'b1;
            if (start_go) state_d = StInit;
         end
         StInit: begin
            Init    = 1'b1;
            state_d = StFetch;
         end
         StFetch: begin
            MemReq = 1'b1;
            Halt   = 1'b1;
            if (MemAck) begin
               instr_d = MemData;
               state_d = StIssue;
            end
         end
         StIssue: begin
            InstrValid = 1'b1;
            // Stall outranks halt, which outranks branch; otherwise PC increments.
            if (Stall) begin
               Halt = 1'b1;
            end else if (HaltReq) begin
               Halt    = 1'b1;
               state_d = StHalted;
            end else if (BranchReq) begin
               Branch_abs = 1'b1;
               Target     = BranchTarget;
               state_d    = StFetch;
            end else begin
               state_d = StFetch;
            end
         end
         StHalted: begin
            Done = 1'b1;
            Halt = 1'b1;
            if (start_go) state_d = StInit;
         end
         default: begin
            Halt    = 1'b1;
            state_d = StIdle;
         end
      endcase
   end

   always_ff @(posedge CLK or posedge Reset) begin
      if (Reset) begin
         state_q <= StIdle;
         instr_q <= '0;
      end else begin
         state_q <= state_d;
         instr_q <= instr_d;
      end
   end

   assign Instr = instr_q;

   // Clear on the accepting Start edge so the count already reads 0 during INIT.
   assign cnt_clear = start_go || (state_q == StInit);
   assign cnt_en    = (state_q == StFetch) || (state_q == StIssue);

   sat_counter #(
      .Width (CNT_W),
      .Max   (CNT_MAX)
   ) u_cycle_cnt (
      .clk_i   (CLK),
      .rst_i   (Reset),
      .clear_i (cnt_clear),
      .en_i    (cnt_en),
      .count_o (CycleCount)
   );

endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed bench for fetch_ctrl: table of ISSUE-cycle decode vectors plus hand sequences.
module tb_fetch_ctrl;

   logic        CLK = 1'b0;
   logic        Reset = 1'b1;
   logic        Start = 1'b0;
   logic        MemAck = 1'b0;
   logic [15:0] MemData = '0;
   logic        Stall = 1'b0;
   logic        BranchReq = 1'b0;
   logic [15:0] BranchTarget = '0;
   logic        HaltReq = 1'b0;
   logic        Init, Halt, Branch_abs, MemReq, InstrValid, Done;
   logic [15:0] Target, Instr, CycleCount;

   int passed = 0;
   int total  = 0;

   fetch_ctrl #(
      .ADDR_W  (16),
      .INSTR_W (16)
   ) dut (
      .CLK          (CLK),
      .Reset        (Reset),
      .Start        (Start),
      .MemAck       (MemAck),
      .MemData      (MemData),
      .Stall        (Stall),
      .BranchReq    (BranchReq),
      .BranchTarget (BranchTarget),
      .HaltReq      (HaltReq),
      .Init         (Init),
      .Halt         (Halt),
      .Branch_abs   (Branch_abs),
      .Target       (Target),
      .MemReq       (MemReq),
      .InstrValid   (InstrValid),
      .Instr        (Instr),
      .Done         (Done),
      .CycleCount   (CycleCount)
   );

   always #5 CLK = ~CLK;

   typedef struct {
      logic        stall;
      logic        hreq;
      logic        breq;
      logic [15:0] tgt;
      logic        e_halt;
      logic        e_babs;
      logic [15:0] e_tgt;
      logic [2:0]  e_next; // {Done, MemReq, InstrValid} one cycle later
   } vec_t;

   localparam logic [2:0] SigHalted = 3'b100;
   localparam logic [2:0] SigFetch  = 3'b010;
   localparam logic [2:0] SigIssue  = 3'b001;

   vec_t vecs [6];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act === exp) passed++;
      else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
   endtask

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   // Steer the DUT from HALTED or ISSUE into FETCH, then fetch one word with immediate ack.
   task automatic to_issue(input logic [15:0] data);
      if (InstrValid) tick();
      if (Done) begin
         Start = 1'b1;
         tick();
         Start = 1'b0;
         tick();
      end
      chk("to_issue_in_fetch", {31'd0, MemReq}, 32'd1);
      MemAck  = 1'b1;
      MemData = data;
      tick();
      MemAck  = 1'b0;
      #1;
      chk("to_issue_instr", {16'd0, Instr}, {16'd0, data});
      chk("to_issue_valid", {31'd0, InstrValid}, 32'd1);
   endtask

   initial begin
      vecs[0] = '{1'b0, 1'b1, 1'b1, 16'h0040, 1'b1, 1'b0, 16'h0000, SigHalted};
      vecs[1] = '{1'b0, 1'b0, 1'b1, 16'h0040, 1'b0, 1'b1, 16'h0040, SigFetch};
      vecs[2] = '{1'b0, 1'b0, 1'b0, 16'hBEEF, 1'b0, 1'b0, 16'h0000, SigFetch};
      vecs[3] = '{1'b1, 1'b0, 1'b1, 16'h1111, 1'b1, 1'b0, 16'h0000, SigIssue};
      vecs[4] = '{1'b0, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b0, 16'h0000, SigHalted};
      vecs[5] = '{1'b0, 1'b0, 1'b1, 16'hFFFF, 1'b0, 1'b1, 16'hFFFF, SigFetch};

      // Reset / IDLE outputs
      #1;
      chk("rst_cmds", {28'd0, Init, Halt, Branch_abs, MemReq}, 32'b0100);
      chk("rst_valid_done", {30'd0, InstrValid, Done}, 32'd0);
      chk("rst_instr", {16'd0, Instr}, 32'd0);
      chk("rst_count", {16'd0, CycleCount}, 32'd0);
      chk("rst_target", {16'd0, Target}, 32'd0);
      tick();
      Reset = 1'b0;

      // Start -> one INIT cycle -> FETCH
      Start = 1'b1;
      tick();
      Start = 1'b0;
      #1;
      chk("init_pulse", {29'd0, Init, Halt, MemReq}, 32'b100);
      chk("init_count", {16'd0, CycleCount}, 32'd0);
      tick();
      chk("fetch_init_gone", {31'd0, Init}, 32'd0);

      // Three FETCH cycles without ack; Start during FETCH is ignored
      for (int i = 0; i < 3; i++) begin
         chk("fetch_wait_req", {30'd0, MemReq, Halt}, 32'b11);
         chk("fetch_wait_noinit", {30'd0, Init, InstrValid}, 32'd0);
         Start = (i == 1);
         if (i == 2) begin
            MemAck  = 1'b1;
            MemData = 16'h1234;
         end
         tick();
         Start = 1'b0;
      end
      MemAck  = 1'b0;
      MemData = 16'h0000;
      #1;
      chk("issue_valid", {31'd0, InstrValid}, 32'd1);
      chk("issue_instr", {16'd0, Instr}, 32'h1234);
      chk("issue_count", {16'd0, CycleCount}, 32'd3);

      // Stall holds ISSUE for 4 cycles despite pending halt/branch
      Stall = 1'b1;
      HaltReq = 1'b1;
      BranchReq = 1'b1;
      BranchTarget = 16'h0040;
      for (int i = 0; i < 4; i++) begin
         #1;
         chk("stall_cmds", {28'd0, Init, Halt, Branch_abs, MemReq}, 32'b0100);
         chk("stall_instr", {15'd0, InstrValid, Instr}, {15'd0, 1'b1, 16'h1234});
         chk("stall_target", {16'd0, Target}, 32'd0);
         tick();
      end
      Stall = 1'b0;
      HaltReq = 1'b0;
      BranchReq = 1'b0;
      BranchTarget = 16'h0000;
      #1;
      chk("incr_cmds", {28'd0, Init, Halt, Branch_abs, InstrValid}, 32'b0001);
      chk("incr_count", {16'd0, CycleCount}, 32'd7);
      tick();
      chk("incr_next_fetch", {29'd0, Done, MemReq, InstrValid}, {29'd0, SigFetch});

      // Table of ISSUE-cycle decode vectors
      for (int i = 0; i < 6; i++) begin
         to_issue(16'hA000 + 16'(i));
         Stall        = vecs[i].stall;
         HaltReq      = vecs[i].hreq;
         BranchReq    = vecs[i].breq;
         BranchTarget = vecs[i].tgt;
         #1;
         chk($sformatf("vec%0d_halt", i), {31'd0, Halt}, {31'd0, vecs[i].e_halt});
         chk($sformatf("vec%0d_babs", i), {31'd0, Branch_abs}, {31'd0, vecs[i].e_babs});
         chk($sformatf("vec%0d_target", i), {16'd0, Target}, {16'd0, vecs[i].e_tgt});
         chk($sformatf("vec%0d_init", i), {31'd0, Init}, 32'd0);
         tick();
         Stall = 1'b0;
         HaltReq = 1'b0;
         BranchReq = 1'b0;
         BranchTarget = 16'h0000;
         #1;
         chk($sformatf("vec%0d_next", i), {29'd0, Done, MemReq, InstrValid},
             {29'd0, vecs[i].e_next});
         chk($sformatf("vec%0d_babs_after", i), {31'd0, Branch_abs}, 32'd0);
      end

      // Saturation: stay in FETCH well past 65535 active cycles
      chk("sat_in_fetch", {31'd0, MemReq}, 32'd1);
      repeat (70000) @(posedge CLK);
      #1;
      chk("sat_count", {16'd0, CycleCount}, 32'h0000FFFF);
      MemAck = 1'b1;
      tick();
      MemAck = 1'b0;
      HaltReq = 1'b1;
      tick();
      HaltReq = 1'b0;
      #1;
      chk("sat_halted_done", {30'd0, Done, Halt}, 32'b11);
      chk("sat_halted_count", {16'd0, CycleCount}, 32'h0000FFFF);
      tick();
      chk("sat_halted_hold", {16'd0, CycleCount}, 32'h0000FFFF);
      Start = 1'b1;
      tick();
      Start = 1'b0;
      #1;
      chk("restart_init", {30'd0, Init, Done}, 32'b10);
      chk("restart_count", {16'd0, CycleCount}, 32'd0);
      tick();
      chk("restart_fetch", {31'd0, MemReq}, 32'd1);

      // Asynchronous reset mid-FETCH
      #2;
      Reset = 1'b1;
      #1;
      chk("async_rst_cmds", {28'd0, Init, Halt, Branch_abs, MemReq}, 32'b0100);
      chk("async_rst_state", {16'd0, Done, InstrValid, 14'd0, CycleCount[1:0]}, 32'd0);
      #1;
      Reset = 1'b0;
      tick();
      chk("post_rst_no_init", {29'd0, Init, Halt, MemReq}, 32'b010);
      Start = 1'b1;
      tick();
      Start = 1'b0;
      #1;
      chk("post_rst_start_init", {31'd0, Init}, 32'd1);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule

// File: doc/fetch_ctrl.md
FETCH_CTRL -- requirements
Module: fetch_ctrl

Interface
REQ-001 SHALL have parameter ADDR_W, default 16, meaning PC/target width.
REQ-002 SHALL have parameter INSTR_W, default 16, meaning instruction word width.
REQ-003 CLK  input  1  sole clock; all state updates on posedge CLK.
REQ-004 Reset  input  1  reset, asynchronous, active-high.
REQ-005 Start  input  1  begin program execution; honoured only in IDLE or HALTED.
REQ-006 MemAck  input  1  instruction memory has MemData valid for the current request.
REQ-007 MemData  input  INSTR_W  instruction word from memory.
REQ-008 Stall  input  1  downstream not ready; hold the current instruction.
REQ-009 BranchReq  input  1  decoded absolute jump for the presented instruction.
REQ-010 BranchTarget  input  ADDR_W  jump destination.
REQ-011 HaltReq  input  1  decoded halt for the presented instruction.
REQ-012 Init  output  1  PC-unit clear command; PC becomes 0.
REQ-013 Halt  output  1  PC-unit hold command.
REQ-014 Branch_abs  output  1  PC-unit load-Target command.
REQ-015 Target  output  ADDR_W  PC-unit jump destination.
REQ-016 MemReq  output  1  instruction fetch request at the current PC.
REQ-017 InstrValid  output  1  Instr is presented to decode.
REQ-018 Instr  output  INSTR_W  captured instruction.
REQ-019 Done  output  1  program halted.
REQ-020 CycleCount  output  16  active cycles since last Start, saturating.

Function
REQ-021 FSM states SHALL be: IDLE, INIT, FETCH, ISSUE, HALTED.
REQ-022 IDLE: Halt=1, all other commands 0; Start -> INIT.
REQ-023 INIT: Init=1 for exactly one cycle; CycleCount cleared to 0; unconditional -> FETCH.
REQ-024 FETCH: MemReq=1, Halt=1; on MemAck, Instr<=MemData -> ISSUE; otherwise remain, with no timeout.
REQ-025 ISSUE: InstrValid=1; if Stall: Halt=1, remain, Instr stable.
REQ-026 ISSUE, no Stall, HaltReq: Halt=1 -> HALTED.
REQ-027 ISSUE, no Stall, BranchReq, no HaltReq: Branch_abs=1, Target=BranchTarget -> FETCH.
REQ-028 ISSUE, no Stall, no HaltReq, no BranchReq: Init/Halt/Branch_abs all 0 (PC increments) -> FETCH.
REQ-029 Priority SHALL be Stall > HaltReq > BranchReq > increment; BranchReq/HaltReq are ignored outside ISSUE.
REQ-030 At most one of Init, Halt, Branch_abs SHALL be 1 in any cycle; Target=0 whenever Branch_abs=0.
REQ-031 HALTED: Done=1, Halt=1; Start -> INIT, with Done dropping in the INIT cycle.
REQ-032 Start in FETCH or ISSUE SHALL be ignored.
REQ-033 CycleCount SHALL increment once per cycle in FETCH or ISSUE, saturate at 16'hFFFF, and hold in IDLE/HALTED.
REQ-034 Command outputs SHALL be combinational from state and inputs; Instr, CycleCount and state are registered.
REQ-035 Minimum instruction period SHALL be 2 cycles (FETCH with immediate MemAck, then ISSUE).

Reset
REQ-036 Reset SHALL asynchronously force state=IDLE, Instr=0, CycleCount=0.
REQ-037 While in IDLE after reset, outputs SHALL be Halt=1 and all others 0.
REQ-038 Reset asserted mid-FETCH or ISSUE SHALL abandon the request with no Init pulse; the next Start produces Init.

Structure
REQ-039 Package fetch_pkg SHALL hold the state enum typedef, the ADDR_W/INSTR_W defaults and the CNT_MAX constant.
REQ-040 The saturating CycleCount SHALL be sub-module sat_counter (inputs clear and enable, async reset).

Verification
REQ-041 Reset, then Start pulse -> Init=1 in the next cycle only, then MemReq=1; CycleCount=0 at the INIT cycle.
REQ-042 MemAck delayed 3 cycles with MemData=16'h1234 -> MemReq held 3 cycles with Halt=1; Instr=16'h1234 with InstrValid=1 the cycle after MemAck.
REQ-043 In ISSUE, BranchReq=1 with BranchTarget=16'h0040 and HaltReq=1 -> HALTED, Branch_abs=0; the repeat with HaltReq=0 -> Branch_abs=1 and Target=16'h0040 for one cycle.
REQ-044 Stall=1 for 4 cycles in ISSUE -> Halt=1 and Instr unchanged for 4 cycles; the increment cycle (all commands 0) follows Stall release.
REQ-045 Force 70000 FETCH/ISSUE cycles -> CycleCount stops at 16'hFFFF; Start from HALTED -> 0.
REQ-046 Reset asserted during FETCH -> state IDLE immediately (asynchronous) with MemReq=0; Start ignored mid-run; Done=1 only in HALTED.
